// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: byte-stream command front-end for the 8-bit combinational ALU.
// Collects opcode/op1/op2 bytes, holds them on the ALU inputs, captures the result
// and flags, and returns them on a valid/ready response port.
// Optional feature macro: ALU_STICKY_FLAGS_EN adds sticky carry/overflow flags.
module alu_cmd_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic [7:0]       alu_op1,
    output logic [7:0]       alu_op2,
    output logic [2:0]       alu_operator,
    input  logic [7:0]       alu_res,
    input  logic             alu_s,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_ov,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_res,
    output logic [3:0]       out_flags,
    output logic             err_timeout,
    output logic [CNT_W-1:0] op_count
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic             sticky_clr,
    output logic             sticky_c,
    output logic             sticky_ov
`endif
);

    localparam logic [2:0] OpNot = 3'b101;
    localparam logic [2:0] OpLsl = 3'b110;
    localparam logic [2:0] OpLsr = 3'b111;

    // Counter only needs to reach TIMEOUT-1; the hit is detected one step early.
    localparam int unsigned TmoW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TmoW-1:0] TmoLast = (TIMEOUT > 0) ? TmoW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {StOpc, StOp1, StOp2, StExec, StResp} state_e;

    state_e          state_q, state_d;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            accept;
    logic            in_frame;
    logic            is_unary;
    logic            tmo_hit;
    logic            resp_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StOpc;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus handshake outputs.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        resp_done = 1'b0;
        in_ready  = (state_q == StOpc) || (state_q == StOp1) || (state_q == StOp2);
        in_frame  = (state_q == StOp1) || (state_q == StOp2);
        accept    = in_valid && in_ready;
        is_unary  = (alu_operator == OpNot) || (alu_operator == OpLsl) ||
                    (alu_operator == OpLsr);
        // An accepted byte always beats a timeout on the same edge.
        tmo_hit   = (TIMEOUT > 0) && in_frame && !accept && (tmo_cnt_q == TmoLast);
        unique case (state_q)
            StOpc: begin
                if (accept) state_d = StOp1;
            end
            StOp1: begin
                if (accept) state_d = is_unary ? StExec : StOp2;
                else if (tmo_hit) state_d = StOpc;
            end
            StOp2: begin
                if (accept) state_d = StExec;
                else if (tmo_hit) state_d = StOpc;
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d   = StOpc;
                    resp_done = 1'b1;
                end
            end
            default: state_d = StOpc;
        endcase
    end

    // Inter-byte idle counter; only meaningful while a frame is partially received.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (!in_frame || accept || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else if (TIMEOUT > 0) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Operand/operator capture, result capture, error pulse and op counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_operator <= '0;
            alu_op1      <= '0;
            alu_op2      <= '0;
            out_res      <= '0;
            out_flags    <= '0;
            err_timeout  <= 1'b0;
            op_count     <= '0;
        end else begin
            err_timeout <= tmo_hit;
            if (accept && (state_q == StOpc)) begin
                alu_operator <= in_data[2:0];
            end
            if (accept && (state_q == StOp1)) begin
                alu_op1 <= in_data;
                if (is_unary) alu_op2 <= '0;
            end
            if (accept && (state_q == StOp2)) begin
                alu_op2 <= in_data;
            end
            if (state_q == StExec) begin
                out_res   <= alu_res;
                out_flags <= {alu_s, alu_c, alu_z, alu_ov};
            end
            if (resp_done) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    // Sticky flags accumulate across captures; a clear during a capture keeps only the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_c  <= 1'b0;
            sticky_ov <= 1'b0;
        end else if (state_q == StExec) begin
            if (sticky_clr) begin
                sticky_c  <= alu_c;
                sticky_ov <= alu_ov;
            end else begin
                sticky_c  <= sticky_c | alu_c;
                sticky_ov <= sticky_ov | alu_ov;
            end
        end else if (sticky_clr) begin
            sticky_c  <= 1'b0;
            sticky_ov <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a behavioural ALU attached.
// Sticky-flag steps are included when ALU_STICKY_FLAGS_EN is defined.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  alu_op1;
    logic [7:0]  alu_op2;
    logic [2:0]  alu_operator;
    logic [7:0]  alu_res;
    logic        alu_s, alu_c, alu_z, alu_ov;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_res;
    logic [3:0]  out_flags;
    logic        err_timeout;
    logic [15:0] op_count;
`ifdef ALU_STICKY_FLAGS_EN
    logic        sticky_clr;
    logic        sticky_c;
    logic        sticky_ov;
`endif

    int vectors = 0;
    int miscompares = 0;

    alu_cmd_sequencer #(
        .TIMEOUT(4),
        .CNT_W  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_operator(alu_operator),
        .alu_res     (alu_res),
        .alu_s       (alu_s),
        .alu_c       (alu_c),
        .alu_z       (alu_z),
        .alu_ov      (alu_ov),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_flags   (out_flags),
        .err_timeout (err_timeout),
        .op_count    (op_count)
`ifdef ALU_STICKY_FLAGS_EN
        ,
        .sticky_clr  (sticky_clr),
        .sticky_c    (sticky_c),
        .sticky_ov   (sticky_ov)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU: carry is the borrow for SUB and the shifted-out bit for shifts.
    always_comb begin
        logic [8:0] wide;
        wide   = '0;
        alu_c  = 1'b0;
        alu_ov = 1'b0;
        case (alu_operator)
            3'b000: begin
                wide   = {1'b0, alu_op1} + {1'b0, alu_op2};
                alu_c  = wide[8];
                alu_ov = (alu_op1[7] == alu_op2[7]) && (wide[7] != alu_op1[7]);
            end
            3'b001: begin
                wide   = {1'b0, alu_op1} - {1'b0, alu_op2};
                alu_c  = wide[8];
                alu_ov = (alu_op1[7] != alu_op2[7]) && (wide[7] != alu_op1[7]);
            end
            3'b010: wide = {1'b0, alu_op1 & alu_op2};
            3'b011: wide = {1'b0, alu_op1 | alu_op2};
            3'b100: wide = {1'b0, alu_op1 ^ alu_op2};
            3'b101: wide = {1'b0, ~alu_op1};
            3'b110: begin
                wide  = {1'b0, alu_op1[6:0], 1'b0};
                alu_c = alu_op1[7];
            end
            default: begin
                wide  = {2'b00, alu_op1[7:1]};
                alu_c = alu_op1[0];
            end
        endcase
        alu_res = wide[7:0];
        alu_s   = wide[7];
        alu_z   = (wide[7:0] == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        check("in_ready_before_byte", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_err"}, err_timeout, 1'b0);
        check({tag, "_op1"}, alu_op1, 8'h00);
        check({tag, "_op2"}, alu_op2, 8'h00);
        check({tag, "_operator"}, alu_operator, 3'b000);
        check({tag, "_res"}, out_res, 8'h00);
        check({tag, "_flags"}, out_flags, 4'h0);
        check({tag, "_count"}, op_count, 16'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        #12;
        check_reset_values("reset");
        rst = 1'b0;
        step();

        // ADD 0x7F + 0x01: signed overflow into negative.
        out_ready = 1'b1;
        send(8'h00);
        send(8'h7F);
        send(8'h01);
        check("add_op1", alu_op1, 8'h7F);
        check("add_op2", alu_op2, 8'h01);
        check("add_exec_no_valid", out_valid, 1'b0);
        check("add_exec_not_ready", in_ready, 1'b0);
        step();
        check("add_valid", out_valid, 1'b1);
        check("add_res", out_res, 8'h80);
        check("add_flags", out_flags, 4'b1001);
        step();
        check("add_done_valid", out_valid, 1'b0);
        check("add_count", op_count, 16'd1);

        // Unary NOT: only two bytes consumed, op2 forced to zero.
        send(8'h05);
        send(8'h0F);
        check("not_op2_zero", alu_op2, 8'h00);
        check("not_exec_not_ready", in_ready, 1'b0);
        step();
        check("not_valid", out_valid, 1'b1);
        check("not_res", out_res, 8'hF0);
        check("not_flags", out_flags, 4'b1000);
        step();
        check("not_count", op_count, 16'd2);

        // Next byte is an opcode: ADD 0xFF + 0x01 gives carry and zero.
        send(8'h00);
        check("next_is_opcode", alu_operator, 3'b000);
        send(8'hFF);
        send(8'h01);
        step();
        check("carry_res", out_res, 8'h00);
        check("carry_flags", out_flags, 4'b0110);
        step();
        check("carry_count", op_count, 16'd3);

        // Backpressure on SUB 0x03 - 0x10 = 0xF3 with borrow.
        out_ready = 1'b0;
        send(8'h01);
        send(8'h03);
        send(8'h10);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1'b1);
            check("bp_res", out_res, 8'hF3);
            check("bp_flags", out_flags, 4'b1100);
            check("bp_not_ready", in_ready, 1'b0);
            check("bp_count_hold", op_count, 16'd3);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_done_valid", out_valid, 1'b0);
        check("bp_done_ready", in_ready, 1'b1);
        check("bp_count", op_count, 16'd4);
        step();
        check("bp_count_once", op_count, 16'd4);

        // Timeout: opcode then four idle cycles drops the frame.
        send(8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            check("tmo_no_err_early", err_timeout, 1'b0);
        end
        step();
        check("tmo_err_pulse", err_timeout, 1'b1);
        check("tmo_back_in_opc", in_ready, 1'b1);
        check("tmo_no_valid", out_valid, 1'b0);
        check("tmo_operator_kept", alu_operator, 3'b001);
        step();
        check("tmo_err_one_cycle", err_timeout, 1'b0);
        // A full AND frame proves the sequencer restarted at the opcode state.
        send(8'h02);
        send(8'hF0);
        send(8'h3C);
        step();
        check("tmo_after_res", out_res, 8'h30);
        check("tmo_after_flags", out_flags, 4'b0000);
        step();
        check("tmo_after_count", op_count, 16'd5);

        // Byte arriving on the fourth idle cycle wins over the timeout.
        send(8'h00);
        for (int i = 0; i < 3; i++) step();
        send(8'h55);
        check("tmo_race_no_err", err_timeout, 1'b0);
        for (int i = 0; i < 3; i++) step();
        send(8'hAA);
        check("tmo_race2_no_err", err_timeout, 1'b0);
        step();
        check("tmo_race_res", out_res, 8'hFF);
        check("tmo_race_flags", out_flags, 4'b1000);
        step();
        check("tmo_race_count", op_count, 16'd6);

        // Reset mid-frame, applied away from the clock edge.
        send(8'h00);
        send(8'h12);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        #1;
        rst = 1'b0;
        step();
        send(8'h00);
        send(8'h20);
        send(8'h22);
        step();
        check("post_rst_res", out_res, 8'h42);
        check("post_rst_flags", out_flags, 4'b0000);
        step();
        check("post_rst_count", op_count, 16'd1);

`ifdef ALU_STICKY_FLAGS_EN
        // Sticky carry survives a later carry-free op until cleared.
        check("sticky_c_reset", sticky_c, 1'b0);
        send(8'h00);
        send(8'hFF);
        send(8'h01);
        step();
        check("sticky_c_set", sticky_c, 1'b1);
        step();
        send(8'h02);
        send(8'h0F);
        send(8'hF0);
        step();
        step();
        check("sticky_c_held", sticky_c, 1'b1);
        check("sticky_ov_clear", sticky_ov, 1'b0);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky_c_cleared", sticky_c, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
